// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
// Shares the single multi-cycle main memory between the I-cache miss path,
// the D-cache miss path and D-cache write-through stores. A miss is served
// as an 8-word block fill: the eight word reads are issued back to back and
// each returning word is forwarded to the requesting cache as it arrives.
// At most one transaction (one fill or one store) is outstanding at a time.
module mem_fill_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss_req,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss_req,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [2:0]  fill_word_idx,
  output logic [15:0] fill_data,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  // Block base keeps address bits [15:4]; the word offset is OR-ed in.
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam logic [2:0]  LAST_WORD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

  // Which requester class received the most recent grant.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // The sequencer counts returns rather than timing them, so the latency
  // needs no logic of its own; it only has to lie in the supported range.
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_fill_arbiter: MEM_LATENCY must lie in 1..15");
  end

  state_t      state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [15:0] blk_base_q, blk_base_d;
  logic [2:0]  iss_q, iss_d;
  logic        iss_done_q, iss_done_d;
  logic [3:0]  ret_q, ret_d;

  logic [15:0] mem_addr_d;
  logic        mem_enable_d;
  logic        mem_wr_d;
  logic [15:0] mem_data_in_d;
  logic        d_wr_ack_d;

  logic        d_pending;
  logic        grant_d_class;
  logic [15:0] sel_miss_addr;
  logic [2:0]  iss_inc;
  logic [3:0]  ret_inc;
  logic        ret_take;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, arbitration, issue/return sequencing and fill outputs.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    blk_base_d    = blk_base_q;
    iss_d         = iss_q;
    iss_done_d    = iss_done_q;
    ret_d         = ret_q;

    mem_addr_d    = '0;
    mem_enable_d  = 1'b0;
    mem_wr_d      = 1'b0;
    mem_data_in_d = '0;
    d_wr_ack_d    = 1'b0;

    i_fill_valid  = 1'b0;
    d_fill_valid  = 1'b0;
    i_fill_done   = 1'b0;
    d_fill_done   = 1'b0;
    fill_word_idx = '0;
    fill_data     = '0;

    // Class D wins when I is idle, or on a tie when I was served last.
    d_pending     = d_wr_req | d_miss_req;
    grant_d_class = d_pending & (~i_miss_req | (last_grant_q == GRANT_I));
    sel_miss_addr = grant_d_class ? d_miss_addr : i_miss_addr;
    iss_inc       = iss_q + 3'd1;
    ret_inc       = ret_q + 4'd1;
    ret_take      = mem_data_valid & ~ret_q[3];

    unique case (state_q)
      IDLE: begin
        if (grant_d_class && d_wr_req) begin
          // Store: one registered write cycle, acked in the same cycle.
          last_grant_d  = GRANT_D;
          state_d       = WRITE;
          mem_enable_d  = 1'b1;
          mem_wr_d      = 1'b1;
          mem_addr_d    = d_wr_addr;
          mem_data_in_d = d_wr_data;
          d_wr_ack_d    = 1'b1;
        end else if (grant_d_class || i_miss_req) begin
          // Block fill: latch the block, issue word 0 right away.
          last_grant_d = grant_d_class ? GRANT_D : GRANT_I;
          state_d      = grant_d_class ? FILL_D : FILL_I;
          blk_base_d   = sel_miss_addr & BLOCK_MASK;
          iss_d        = '0;
          iss_done_d   = 1'b0;
          ret_d        = '0;
          mem_enable_d = 1'b1;
          mem_addr_d   = sel_miss_addr & BLOCK_MASK;
        end
      end

      WRITE: begin
        state_d = IDLE;
      end

      FILL_I, FILL_D: begin
        // Issue phase: word iss is on the bus now; queue up the next one.
        if (!iss_done_q) begin
          if (iss_q == LAST_WORD) begin
            iss_done_d = 1'b1;
          end else begin
            iss_d        = iss_inc;
            mem_enable_d = 1'b1;
            mem_addr_d   = blk_base_q | {12'h000, iss_inc, 1'b0};
          end
        end
        // Return phase: forward each returning word in arrival order.
        if (ret_take) begin
          i_fill_valid  = (state_q == FILL_I);
          d_fill_valid  = (state_q == FILL_D);
          fill_word_idx = ret_q[2:0];
          fill_data     = mem_data_out;
          ret_d         = ret_inc;
          if (ret_q[2:0] == LAST_WORD) begin
            i_fill_done = (state_q == FILL_I);
            d_fill_done = (state_q == FILL_D);
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fill bookkeeping, grant history and the registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_I;
      blk_base_q   <= '0;
      iss_q        <= '0;
      iss_done_q   <= 1'b0;
      ret_q        <= '0;
      mem_addr     <= '0;
      mem_enable   <= 1'b0;
      mem_wr       <= 1'b0;
      mem_data_in  <= '0;
      d_wr_ack     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      blk_base_q   <= blk_base_d;
      iss_q        <= iss_d;
      iss_done_q   <= iss_done_d;
      ret_q        <= ret_d;
      mem_addr     <= mem_addr_d;
      mem_enable   <= mem_enable_d;
      mem_wr       <= mem_wr_d;
      mem_data_in  <= mem_data_in_d;
      d_wr_ack     <= d_wr_ack_d;
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter
// Drives the arbiter from three requester agents and a fixed-latency memory
// model. The reference model works at transaction level: when the arbiter
// is free and requests are pending it picks the winner and writes the whole
// expected per-cycle trace of that transaction (bus, fill words, done
// pulses) into a cycle-indexed table, which is compared every cycle.
module tb_mem_fill_arbiter;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        i_miss_req;
  logic [15:0] i_miss_addr;
  logic        d_miss_req;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        d_wr_ack;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        i_fill_done;
  logic        d_fill_done;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;

  mem_fill_arbiter #(.MEM_LATENCY(L)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss_req     (i_miss_req),
    .i_miss_addr    (i_miss_addr),
    .d_miss_req     (d_miss_req),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .d_wr_ack       (d_wr_ack),
    .i_fill_valid   (i_fill_valid),
    .d_fill_valid   (d_fill_valid),
    .fill_word_idx  (fill_word_idx),
    .fill_data      (fill_data),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle; absent cycles expect everything low.
  typedef struct packed {
    logic        en;
    logic        wr;
    logic        ack;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ifv;
    logic        dfv;
    logic        idone;
    logic        ddone;
    logic [2:0]  idx;
    logic [15:0] fdata;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  exp_t        exp_q [int];
  rd_t         rdq [$];

  int          cyc;
  int          n_total;
  int          n_pass;
  int          n_fail;
  logic [15:0] salt;
  logic        stray;
  logic        rst_next;

  // Model state: first cycle the arbiter is free, and who won last.
  int          free_at;
  logic        last_i;

  // Requester agents: level, address/data, cycle they drop, raise chance.
  logic        i_act, dm_act, dw_act;
  logic [15:0] i_addr, dm_addr, dw_addr, dw_data;
  int          i_drop, dm_drop, dw_drop;
  int unsigned i_pct, dm_pct, dw_pct;
  int          t_grant;

  function automatic exp_t exp_at(input int c);
    if (exp_q.exists(c)) return exp_q[c];
    return '0;
  endfunction

  task automatic add_write(input int t, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e = exp_at(t + 1);
    e.en = 1'b1; e.wr = 1'b1; e.ack = 1'b1; e.addr = a; e.din = d;
    exp_q[t + 1] = e;
  endtask

  // Words issued at t+1..t+8, returned L cycles later, done with word 7.
  task automatic add_fill(input int t, input logic [15:0] a, input logic is_i);
    exp_t        e;
    logic [15:0] base;
    logic [15:0] waddr;
    base = a & 16'hFFF0;
    for (int w = 0; w < 8; w++) begin
      waddr = base + 16'(2 * w);
      e = exp_at(t + 1 + w);
      e.en = 1'b1; e.addr = waddr;
      exp_q[t + 1 + w] = e;
      e = exp_at(t + 1 + L + w);
      if (is_i) e.ifv = 1'b1; else e.dfv = 1'b1;
      e.idx   = 3'(w);
      e.fdata = waddr ^ salt;
      if (w == 7) begin
        if (is_i) e.idone = 1'b1; else e.ddone = 1'b1;
      end
      exp_q[t + 1 + L + w] = e;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h (failure %0d)",
             tag, cyc, obs, expv, n_fail);
    end
  endtask

  // One clock cycle: memory, agents, model, then compare at the falling edge.
  task automatic step();
    exp_t e;
    logic fv;
    @(posedge clk);
    #1;
    cyc++;

    // Memory: returns the word due now, then accepts this cycle's read.
    mem_data_valid = 1'b0;
    mem_data_out   = 16'($urandom);
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = rdq[0].data;
      void'(rdq.pop_front());
    end
    if (stray) begin
      mem_data_valid = 1'b1;
      stray = 1'b0;
    end
    if (mem_enable && !mem_wr)
      rdq.push_back('{due: cyc + L, data: mem_addr ^ salt});

    // Agents: raise at random while low, drop the cycle after done/ack.
    if (!i_act && $urandom_range(99) < i_pct) begin
      i_act = 1'b1; i_addr = 16'($urandom);
    end
    if (!dm_act && $urandom_range(99) < dm_pct) begin
      dm_act = 1'b1; dm_addr = 16'($urandom);
    end
    if (!dw_act && $urandom_range(99) < dw_pct) begin
      dw_act = 1'b1; dw_addr = 16'($urandom); dw_data = 16'($urandom);
    end
    if (i_act && cyc == i_drop)   begin i_act = 1'b0;  i_drop = -1;  end
    if (dm_act && cyc == dm_drop) begin dm_act = 1'b0; dm_drop = -1; end
    if (dw_act && cyc == dw_drop) begin dw_act = 1'b0; dw_drop = -1; end
    if (!rst_next) begin
      i_act = 1'b0; dm_act = 1'b0; dw_act = 1'b0;
      i_drop = -1; dm_drop = -1; dw_drop = -1;
    end

    rst_n       = rst_next;
    i_miss_req  = i_act;
    i_miss_addr = i_addr;
    d_miss_req  = dm_act;
    d_miss_addr = dm_addr;
    d_wr_req    = dw_act;
    d_wr_addr   = dw_addr;
    d_wr_data   = dw_data;

    // Reference model: grant only when the previous transaction is over.
    if (!rst_n) begin
      exp_q.delete();
      free_at = cyc;
      last_i  = 1'b1;
    end else if (cyc >= free_at) begin
      if ((dw_act || dm_act) && (!i_act || last_i)) begin
        last_i = 1'b0;
        if (dw_act) begin
          add_write(cyc, dw_addr, dw_data);
          dw_drop = cyc + 2;
          free_at = cyc + 2;
        end else begin
          add_fill(cyc, dm_addr, 1'b0);
          dm_drop = cyc + 9 + L;
          free_at = cyc + 9 + L;
        end
      end else if (i_act) begin
        last_i = 1'b1;
        add_fill(cyc, i_addr, 1'b1);
        i_drop  = cyc + 9 + L;
        free_at = cyc + 9 + L;
      end
    end

    @(negedge clk);
    e  = exp_at(cyc);
    fv = e.ifv | e.dfv;
    if (!rst_n) begin
      check("reset_zero",
            64'({d_wr_ack, i_fill_valid, d_fill_valid, fill_word_idx, fill_data,
                 i_fill_done, d_fill_done, mem_addr, mem_enable, mem_wr, mem_data_in}),
            64'(0));
    end else begin
      check("mem_bus",
            64'({mem_enable, mem_wr, d_wr_ack,
                 e.en ? mem_addr : 16'h0000, e.wr ? mem_data_in : 16'h0000}),
            64'({e.en, e.wr, e.ack, e.addr, e.din}));
      check("fill",
            64'({i_fill_valid, d_fill_valid, i_fill_done, d_fill_done,
                 fv ? fill_word_idx : 3'd0, fv ? fill_data : 16'h0000}),
            64'({e.ifv, e.dfv, e.idone, e.ddone, e.idx, e.fdata}));
    end
  endtask

  initial begin
    cyc = 0; n_total = 0; n_pass = 0; n_fail = 0;
    salt = 16'h0000; stray = 1'b0; rst_next = 1'b0;
    free_at = 0; last_i = 1'b1;
    i_act = 1'b0; dm_act = 1'b0; dw_act = 1'b0;
    i_addr = '0; dm_addr = '0; dw_addr = '0; dw_data = '0;
    i_drop = -1; dm_drop = -1; dw_drop = -1;
    i_pct = 0; dm_pct = 0; dw_pct = 0;
    t_grant = 0;
    rst_n = 1'b0;
    i_miss_req = 1'b0; i_miss_addr = '0;
    d_miss_req = 1'b0; d_miss_addr = '0;
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    mem_data_out = '0; mem_data_valid = 1'b0;

    // Reset: all outputs low.
    repeat (3) step();
    rst_next = 1'b1;
    repeat (2) step();

    // I-miss at 0x1237, memory returns data = address.
    i_act = 1'b1; i_addr = 16'h1237;
    repeat (9 + L + 3) step();

    // Write-through store 0x0040 <- 0xBEEF.
    dw_act = 1'b1; dw_addr = 16'h0040; dw_data = 16'hBEEF;
    repeat (4) step();

    // I-miss and D-miss together right after reset: D first, then I.
    rst_next = 1'b0;
    repeat (2) step();
    rst_next = 1'b1;
    i_act = 1'b1; i_addr = 16'h2A5C;
    dm_act = 1'b1; dm_addr = 16'h7F13;
    repeat (2 * (9 + L) + 4) step();

    // Stray memory valid in IDLE, then a D fill still starts at word 0.
    stray = 1'b1;
    repeat (3) step();
    dm_act = 1'b1; dm_addr = 16'h0ABC;
    repeat (9 + L + 2) step();

    // I-miss kept pending while D writes keep coming: grants alternate.
    i_pct = 100; dw_pct = 100;
    repeat (80) step();
    i_pct = 0; dw_pct = 0;
    repeat (40) step();

    // Reset after fill word 3 has returned; later returns are ignored.
    i_act = 1'b1; i_addr = 16'($urandom);
    step();
    t_grant = cyc;
    while (cyc < t_grant + 4 + L) step();
    rst_next = 1'b0;
    repeat (3) step();
    rst_next = 1'b1;
    repeat (8) step();

    // Randomized traffic from all three requesters.
    salt = 16'($urandom);
    i_pct = 25; dm_pct = 15; dw_pct = 20;
    repeat (1500) step();
    i_pct = 0; dm_pct = 0; dw_pct = 0;
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Arbitrates the single shared multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and data-cache write-through stores. On a miss it sequences an 8-word block fill: it issues the eight word addresses to memory back to back, then returns each word to the requesting cache as it comes back. It sits between the two caches and the main memory instance in `cpu`, and replaces the direct `memory1c` hookups once caches are added.

## Interface
- `MEM_LATENCY`, 4: cycles from a read issue (`mem_enable=1`, `mem_wr=0`) to the matching `mem_data_valid`. Legal range is 1..15.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `i_miss_req` in 1: I-cache block fill request; held high until `i_fill_done`.
- `i_miss_addr` in 16: I-miss byte address; bits [3:0] are ignored.
- `d_miss_req` in 1: D-cache block fill request; held high until `d_fill_done`.
- `d_miss_addr` in 16: D-miss byte address; bits [3:0] are ignored.
- `d_wr_req` in 1: write-through store request; held high until `d_wr_ack`.
- `d_wr_addr` in 16: store byte address.
- `d_wr_data` in 16: store data.
- `d_wr_ack` out 1: one-cycle pulse; the store is issued to memory this cycle.
- `i_fill_valid` out 1: `fill_data` is a word for the I-cache this cycle.
- `d_fill_valid` out 1: `fill_data` is a word for the D-cache this cycle.
- `fill_word_idx` out 3: word index within the block for the current fill word.
- `fill_data` out 16: returned word (driven from `mem_data_out`).
- `i_fill_done` out 1: pulses with the 8th `i_fill_valid`.
- `d_fill_done` out 1: pulses with the 8th `d_fill_valid`.
- `mem_addr` out 16: registered memory address.
- `mem_enable` out 1: registered memory enable.
- `mem_wr` out 1: registered memory write enable.
- `mem_data_in` out 16: registered memory write data.
- `mem_data_out` in 16: memory read data.
- `mem_data_valid` in 1: memory read data valid.

## Operation
- States:
  - IDLE.
  - WRITE (1 cycle).
  - FILL_I.
  - FILL_D.
- Arbitration is evaluated only in IDLE.
  - Requester classes: D = {`d_wr_req`, `d_miss_req`} and I = {`i_miss_req`}.
  - If only one class is pending, that class is granted.
  - If both classes are pending, the class not granted last is granted.
  - Within class D, `d_wr_req` wins over `d_miss_req`.
- `last_grant` updates on each grant. It resets to I, so the first tie goes to D.
- WRITE:
  - Drive `mem_enable=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_data_in=d_wr_data`, `d_wr_ack=1`.
  - Next state is IDLE.
- FILL_x entry:
  - Latch `blk = addr[15:4]` from the granted request.
  - Clear the 3-bit issue counter `iss` and the 4-bit return counter `ret`.
- FILL_x issue phase:
  - While `iss_done=0`, drive `mem_enable=1`, `mem_wr=0`, `mem_addr={blk, iss, 1'b0}`.
  - `iss` increments each cycle. After issuing word 7, set `iss_done`; `iss` does not wrap into a second issue.
- FILL_x return phase:
  - Each cycle with `mem_data_valid=1` and `ret<8` asserts `x_fill_valid`, with `fill_word_idx=ret[2:0]` and `fill_data=mem_data_out`; then `ret` increments.
  - When `ret==7` and `mem_data_valid=1`, also assert `x_fill_done`. Next state is IDLE.
- `mem_data_valid` is ignored in IDLE and WRITE: no fill outputs are asserted.
- Requester rules:
  - A requester drops its request in the cycle after its done/ack pulse.
  - A request still high when IDLE samples it is treated as a new request.
- Reset, asserted at any time, including mid-fill:
  - State goes to IDLE; `iss`, `ret` and `iss_done` clear; `last_grant` goes to I.
  - All `mem_*` outputs go to 0 and no done pulse is produced; any partial fill is discarded.
  - Data still in flight from memory after reset is ignored, because the block is in IDLE.

## Timing
- All outputs are 0 during reset. Fill outputs are combinational from `mem_data_valid` and state; `mem_*` and `d_wr_ack` are registered.
- A request sampled in IDLE at cycle T moves the state at T+1.
- WRITE: `mem_enable`/`mem_wr`/`d_wr_ack` are high at T+1; IDLE at T+2.
- FILL issue: words 0..7 are issued at T+1..T+8.
  - Returns arrive at T+1+L..T+8+L, where L = `MEM_LATENCY`.
  - `x_fill_done` is at T+8+L (T+12 when L=4); IDLE at T+9+L.
- At most one outstanding transaction (fill or write) at any time. Reads are never overlapped across grants.

## Test plan
- I-miss only, `i_miss_addr=0x1237`, memory returns data=address, L=4, request sampled at T:
  - `mem_addr` = 0x1230, 0x1232, ..., 0x123E at T+1..T+8.
  - `i_fill_valid` at T+5..T+12 with idx 0..7 and data 0x1230..0x123E.
  - `i_fill_done` only at T+12.
- I-miss and D-miss asserted together right after reset:
  - D granted first.
  - I granted in the first IDLE cycle after `d_fill_done`, with I fill issue starting 2 cycles after `d_fill_done`.
- `d_wr_req`, addr 0x0040, data 0xBEEF, in IDLE at T:
  - At T+1: `mem_enable=1`, `mem_wr=1`, `mem_addr=0x0040`, `mem_data_in=0xBEEF`, `d_wr_ack=1`.
  - `mem_wr` low at T+2.
- I-miss pending while repeated D writes arrive:
  - Grant order is D, I, D, I (alternation); I is never starved.
- `rst_n` low after fill word 3 has returned:
  - All outputs go to 0 immediately; no `x_fill_done`.
  - The remaining `mem_data_valid` pulses produce no `fill_valid`.
- Stray `mem_data_valid=1` in IDLE:
  - No `i_fill_valid` or `d_fill_valid`, and state is unchanged.
